// File: rtl/snake_pkg.sv
// Shared snake-game types and constants: map geometry, tile encoding and the
// food placement state machine encoding.
package snake_pkg;

  localparam int MAP_WIDTH  = 16;
  localparam int MAP_HEIGHT = 16;
  localparam int COORD_W    = $clog2((MAP_WIDTH > MAP_HEIGHT) ? MAP_WIDTH : MAP_HEIGHT);

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] FOOD_LFSR_TAPS = 16'hB400;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WALL   = 2'd1,
    SNAKE1 = 2'd2,
    SNAKE2 = 2'd3
  } tile_e;

  typedef struct packed {
    tile_e [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
    coord_t                                head1_x;
    coord_t                                head1_y;
    coord_t                                head2_x;
    coord_t                                head2_y;
  } map_s;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SCAN,
    PLACED,
    FULL
  } food_state_e;

endpackage

// File: rtl/food_ctrl_if.sv
// Connection between the movement stage (master) and the food controller
// (slave): registered map and step pulses in, growth requests and food out.
interface food_ctrl_if;
  import snake_pkg::*;

  map_s   map;
  logic   tick1;
  logic   rcvdir;
  logic   eaten1;
  logic   eaten2;
  coord_t food_x;
  coord_t food_y;
  logic   food_valid;
  logic   map_full;

  modport master (
    output map, tick1, rcvdir,
    input  eaten1, eaten2, food_x, food_y, food_valid, map_full
  );

  modport slave (
    input  map, tick1, rcvdir,
    output eaten1, eaten2, food_x, food_y, food_valid, map_full
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left with the feedback bit
// entering at the LSB. An all-zero seed would lock up, so it becomes 1.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] TAPS = FOOD_LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_nz;

  assign seed_nz = (seed == '0) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (rst) q <= seed_nz;
    else     q <= {q[14:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/food_ctrl.sv
// Places one food item on an EMPTY tile not under a snake head, and raises a
// held growth request when a head lands on it until that snake's step consumes it.
module food_ctrl
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned SCAN_LIMIT = MAP_WIDTH * MAP_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  food_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_LIMIT + 1);

  food_state_e      state, state_n;
  logic [15:0]      lfsr;
  coord_t           cx, cy, cx_n, cy_n;
  coord_t           fx_n, fy_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             e1_n, e2_n, fv_n, mf_n;
  logic [COORD_W:0] lx, ly;
  logic             accept, hit1, hit2;
  logic             unused_lfsr_hi;

  lfsr16 #(.TAPS(FOOD_LFSR_TAPS)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:2*COORD_W];

  // One extra bit so the range check is a real comparison for any map size.
  assign lx = {1'b0, lfsr[COORD_W-1:0]};
  assign ly = {1'b0, lfsr[2*COORD_W-1:COORD_W]};

  assign accept = (bus.map.tiles[cy][cx] == EMPTY)
               && !((cx == bus.map.head1_x) && (cy == bus.map.head1_y))
               && !((cx == bus.map.head2_x) && (cy == bus.map.head2_y));

  assign hit1 = (bus.map.head1_x == bus.food_x) && (bus.map.head1_y == bus.food_y);
  assign hit2 = (bus.map.head2_x == bus.food_x) && (bus.map.head2_y == bus.food_y);

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    cnt_n   = cnt;
    fx_n    = bus.food_x;
    fy_n    = bus.food_y;
    fv_n    = bus.food_valid;
    mf_n    = bus.map_full;
    e1_n    = bus.eaten1;
    e2_n    = bus.eaten2;

    // A step pulse consumes a pending growth; a detection below overrides it.
    if (bus.tick1  && bus.eaten1) e1_n = 1'b0;
    if (bus.rcvdir && bus.eaten2) e2_n = 1'b0;

    case (state)
      IDLE: state_n = START;

      START: begin
        cx_n    = (lx >= (COORD_W+1)'(MAP_WIDTH))  ? coord_t'(1) : lx[COORD_W-1:0];
        cy_n    = (ly >= (COORD_W+1)'(MAP_HEIGHT)) ? coord_t'(1) : ly[COORD_W-1:0];
        cnt_n   = '0;
        state_n = SCAN;
      end

      SCAN: begin
        if (accept) begin
          fx_n    = cx;
          fy_n    = cy;
          fv_n    = 1'b1;
          mf_n    = 1'b0;
          state_n = PLACED;
        end else begin
          if (cx == coord_t'(MAP_WIDTH - 1)) begin
            cx_n = '0;
            cy_n = (cy == coord_t'(MAP_HEIGHT - 1)) ? '0 : cy + 1'b1;
          end else begin
            cx_n = cx + 1'b1;
          end
          cnt_n = cnt + 1'b1;
          if (cnt_n == CNT_W'(SCAN_LIMIT)) begin
            mf_n    = 1'b1;
            state_n = FULL;
          end
        end
      end

      PLACED: begin
        if (hit1) begin
          e1_n    = 1'b1;
          fv_n    = 1'b0;
          state_n = START;
        end else if (hit2) begin
          e2_n    = 1'b1;
          fv_n    = 1'b0;
          state_n = START;
        end
      end

      FULL: begin
        fv_n = 1'b0;
        if (bus.tick1 || bus.rcvdir) state_n = START;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cx             <= '0;
      cy             <= '0;
      cnt            <= '0;
      bus.food_x     <= '0;
      bus.food_y     <= '0;
      bus.food_valid <= 1'b0;
      bus.map_full   <= 1'b0;
      bus.eaten1     <= 1'b0;
      bus.eaten2     <= 1'b0;
    end else begin
      state          <= state_n;
      cx             <= cx_n;
      cy             <= cy_n;
      cnt            <= cnt_n;
      bus.food_x     <= fx_n;
      bus.food_y     <= fy_n;
      bus.food_valid <= fv_n;
      bus.map_full   <= mf_n;
      bus.eaten1     <= e1_n;
      bus.eaten2     <= e2_n;
    end
  end

endmodule
